// File: rtl/comparator_unit_pkg.sv
// comparator_unit_pkg: result struct and reset constant shared by comparator_unit and comparator_core
package comparator_unit_pkg;
  typedef struct packed {
    logic eq;
    logic ne;
    logic lt;
    logic gt;
    logic le;
    logic ge;
  } cmp_result_t;
  localparam cmp_result_t CMP_RESULT_RESET = '{eq: 1'b1, ne: 1'b0, lt: 1'b0, gt: 1'b0, le: 1'b1, ge: 1'b1};
endpackage

// File: rtl/comparator_core.sv
// comparator_core: combinational eq/ne/lt/gt/le/ge of a vs b (ports a, b, signed_mode, [mask with COMPARATOR_UNIT_MASK_EN], res)
module comparator_core
  import comparator_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
`ifdef COMPARATOR_UNIT_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output cmp_result_t      res
);
  // flipping the sign bit maps two's-complement order onto unsigned order
  logic [WIDTH-1:0] flip, ax, bx;
  logic eq, lt, gt;
  assign flip = WIDTH'(signed_mode) << (WIDTH - 1);
  assign ax = a ^ flip;
  assign bx = b ^ flip;
`ifdef COMPARATOR_UNIT_MASK_EN
  assign eq = ((a ^ b) & mask) == '0;
`else
  assign eq = a == b;
`endif
  assign lt = ax < bx;
  assign gt = ax > bx;
  assign res = '{eq: eq, ne: ~eq, lt: lt, gt: gt, le: ~gt, ge: ~lt};
endmodule

// File: rtl/comparator_unit.sv
// comparator_unit: combinational equality c plus registered, valid-qualified relation set; mask port with COMPARATOR_UNIT_MASK_EN
// ports: clk, reset (async active-low), a, b, [mask], in_valid, signed_mode -> c, out_valid, eq_q, ne_q, lt_q, gt_q, le_q, ge_q
module comparator_unit
  import comparator_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_UNIT_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic             c,
  input  logic             in_valid,
  input  logic             signed_mode,
  output logic             out_valid,
  output logic             eq_q,
  output logic             ne_q,
  output logic             lt_q,
  output logic             gt_q,
  output logic             le_q,
  output logic             ge_q
);
  cmp_result_t res, res_q;
  comparator_core #(.WIDTH(WIDTH)) u_core (
    .a(a),
    .b(b),
    .signed_mode(signed_mode),
`ifdef COMPARATOR_UNIT_MASK_EN
    .mask(mask),
`endif
    .res(res)
  );
  assign c = res.eq;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      res_q <= CMP_RESULT_RESET;
    end else begin
      out_valid <= in_valid;
      if (in_valid) res_q <= res;
    end
  end
  assign eq_q = res_q.eq;
  assign ne_q = res_q.ne;
  assign lt_q = res_q.lt;
  assign gt_q = res_q.gt;
  assign le_q = res_q.le;
  assign ge_q = res_q.ge;
endmodule

// File: tb/tb_comparator_unit.sv
// tb_comparator_unit: table-driven, hand-written and randomized checks of comparator_unit against a numeric reference model
module tb_comparator_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] a = '0, b = '0, mask = '1;
  logic in_valid = 1'b0, signed_mode = 1'b0;
  logic c, out_valid, eq_q, ne_q, lt_q, gt_q, le_q, ge_q;
  int tests = 0, fails = 0;
  logic [6:0] got;
  logic [5:0] exp_q;
  logic exp_v;
  assign got = {out_valid, eq_q, ne_q, lt_q, gt_q, le_q, ge_q};
  comparator_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
`ifdef COMPARATOR_UNIT_MASK_EN
    .mask(mask),
`endif
    .c(c),
    .in_valid(in_valid),
    .signed_mode(signed_mode),
    .out_valid(out_valid),
    .eq_q(eq_q),
    .ne_q(ne_q),
    .lt_q(lt_q),
    .gt_q(gt_q),
    .le_q(le_q),
    .ge_q(ge_q)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    logic [5:0]  rel;
  } vec_t;
  vec_t vecs[9];
  function automatic logic [5:0] model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] m, input logic s);
    longint sx, sy;
    logic e;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    e = (x & m) == (y & m);
    return {e, !e, sx < sy, sx > sy, sx <= sy, sx >= sy};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    vecs[0] = '{32'd5, 32'd5, 1'b0, 1'b1, 6'b100011};
    vecs[1] = '{32'd7, 32'd3, 1'b0, 1'b0, 6'b010101};
    vecs[2] = '{32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 6'b011010};
    vecs[3] = '{32'd123, 32'd123, 1'b0, 1'b1, 6'b100011};
    vecs[4] = '{32'd1, 32'd2, 1'b0, 1'b0, 6'b011010};
    vecs[5] = '{32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 6'b010101};
    vecs[6] = '{32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 6'b011010};
    vecs[7] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 6'b011010};
    vecs[8] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 6'b010101};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = $urandom;
      b = (i == 1) ? a : $urandom;
      in_valid = 1'b1;
      #1 chk("reset_c", 32'(c), 32'(a == b));
      @(posedge clk);
      #1 chk("reset_state", 32'(got), 32'b0100011);
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("post_reset_idle", 32'(got), 32'b0100011);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a = vecs[i].a;
      b = vecs[i].b;
      signed_mode = vecs[i].s;
      in_valid = 1'b1;
      #1 chk($sformatf("vec%0d_c", i), 32'(c), 32'(vecs[i].c));
      @(posedge clk);
      #1 chk($sformatf("vec%0d_q", i), 32'(got), 32'({1'b1, vecs[i].rel}));
    end
    @(negedge clk);
    a = 32'd9;
    b = 32'd4;
    signed_mode = 1'b0;
    @(posedge clk);
    #1 chk("pulse_q", 32'(got), 32'b1010101);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = (i == 1) ? 32'd77 : $urandom;
      b = (i == 1) ? 32'd77 : $urandom;
      #1 chk("hold_c", 32'(c), 32'(a == b));
      @(posedge clk);
      #1 chk("hold_q", 32'(got), 32'b0010101);
    end
    @(negedge clk);
    a = 32'd2;
    b = 32'd8;
    in_valid = 1'b1;
    @(posedge clk);
    #1 chk("pre_async", 32'(got), 32'b1011010);
    #2 reset = 1'b0;
    #1 chk("async_reset", 32'(got), 32'b0100011);
    chk("async_reset_c", 32'(c), 32'(a == b));
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("reset_no_survive", 32'(got), 32'b0100011);
`ifdef COMPARATOR_UNIT_MASK_EN
    @(negedge clk);
    a = 32'h12345678;
    b = 32'h12FF5678;
    mask = 32'hFF00FFFF;
    in_valid = 1'b1;
    #1 chk("mask_c", 32'(c), 32'd1);
    @(posedge clk);
    #1 chk("mask_q", 32'(got), 32'({1'b1, model(a, b, mask, 1'b0)}));
    mask = '1;
`endif
    exp_v = 1'b0;
    exp_q = 6'b100011;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'd1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      signed_mode = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      #1 chk("rand_c", 32'(c), 32'((a & mask) == (b & mask)));
      exp_v = in_valid;
      if (in_valid) exp_q = model(a, b, mask, signed_mode);
      @(posedge clk);
      #1 chk("rand_q", 32'(got), 32'({exp_v, exp_q}));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
